// File: rtl/door_pkg.sv
// door_pkg: shared types for the garage-door travel monitor.
//   state_e : FSM state encoding; IDLE is 2'b00 to line up with the
//             door controller's own encoding.
//   fault_e : fault cause reported on fault_code.
package door_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RISING  = 2'b01,
    ST_FALLING = 2'b10,
    ST_FAULT   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_CONFLICT = 2'b01,
    FLT_STALL    = 2'b10,
    FLT_OVERRUN  = 2'b11
  } fault_e;

endpackage

// File: rtl/door_travel_monitor_if.sv
// door_travel_monitor_if: motor command / limit bus between the door
// controller (master) and the travel monitor (slave).
//   UP_motor, DN_motor : motor commands from the controller
//   enc_tick           : one-cycle pulse per travel increment
//   fault_clr          : fault acknowledge (level)
//   UP_MAX, DN_MAX     : open / closed limit flags
//   position           : door position in encoder ticks
//   motor_en, fault    : driver enable and fault flag
//   fault_code         : first fault cause
interface door_travel_monitor_if
  import door_pkg::*;
#(
  parameter int POS_W = 8
);
  logic             UP_motor;
  logic             DN_motor;
  logic             enc_tick;
  logic             fault_clr;
  logic             UP_MAX;
  logic             DN_MAX;
  logic [POS_W-1:0] position;
  logic             motor_en;
  logic             fault;
  fault_e           fault_code;

  modport master (
    output UP_motor, DN_motor, enc_tick, fault_clr,
    input  UP_MAX, DN_MAX, position, motor_en, fault, fault_code
  );

  modport slave (
    input  UP_motor, DN_motor, enc_tick, fault_clr,
    output UP_MAX, DN_MAX, position, motor_en, fault, fault_code
  );
endinterface

// File: rtl/door_stall_timer.sv
// door_stall_timer: counts cycles without an encoder tick while the door
// is being driven in one direction.
//   clk, rst : clock, async active-low reset
//   run      : 1 while the monitor stays in the same travel state
//   tick     : encoder tick this cycle
//   expired  : the tick-free window is used up and no tick arrived now
module door_stall_timer #(
  parameter int STALL_CYC = 1000,
  parameter int STALL_W   = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic tick,
  output logic expired
);

  localparam logic [STALL_W-1:0] LAST = STALL_W'(STALL_CYC - 1);

  logic [STALL_W-1:0] cnt_r;

  // Tick-free cycle counter; any tick or leaving the travel state restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (!run || tick) begin
      cnt_r <= '0;
    end else if (cnt_r != LAST) begin
      cnt_r <= cnt_r + STALL_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A tick arriving in the final cycle still rescues the travel.
  assign expired = (cnt_r == LAST) && !tick;

endmodule

// File: rtl/door_travel_monitor.sv
// door_travel_monitor: tracks door position from encoder ticks, produces
// the UP_MAX/DN_MAX limits and shuts the motor drivers off on a command
// conflict, stall or limit overrun.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : door_travel_monitor_if slave port (commands in, status out)
module door_travel_monitor
  import door_pkg::*;
#(
  parameter int POS_W     = 8,
  parameter int POS_MAX   = 200,
  parameter int STALL_CYC = 1000,
  parameter int STALL_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  door_travel_monitor_if.slave   bus
);

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);

  state_e           state_r, state_nxt_s;
  fault_e           code_r, code_nxt_s;
  logic [POS_W-1:0] pos_r, pos_nxt_s;
  logic             fault_r;
  logic             at_top_s, at_bot_s;
  logic             both_s, none_s, up_only_s, dn_only_s;
  logic             run_s, expired_s;

  assign at_top_s  = (pos_r == POS_TOP);
  assign at_bot_s  = (pos_r == '0);
  assign both_s    = bus.UP_motor && bus.DN_motor;
  assign none_s    = !bus.UP_motor && !bus.DN_motor;
  assign up_only_s = bus.UP_motor && !bus.DN_motor;
  assign dn_only_s = !bus.UP_motor && bus.DN_motor;

  // Stall window only accumulates while the travel state is unchanged.
  assign run_s = ((state_r == ST_RISING) || (state_r == ST_FALLING)) &&
                 (state_nxt_s == state_r);

  door_stall_timer #(
    .STALL_CYC (STALL_CYC),
    .STALL_W   (STALL_W)
  ) u_stall (
    .clk     (clk),
    .rst     (rst),
    .run     (run_s),
    .tick    (bus.enc_tick),
    .expired (expired_s)
  );

  // Next-state, position and fault-cause decode; conflict > overrun > stall > direction.
  always_comb begin
    state_nxt_s = state_r;
    pos_nxt_s   = pos_r;
    code_nxt_s  = code_r;
    case (state_r)
      ST_IDLE: begin
        if (both_s) begin
          state_nxt_s = ST_FAULT;
          code_nxt_s  = FLT_CONFLICT;
        end else if (up_only_s && !at_top_s) begin
          state_nxt_s = ST_RISING;
        end else if (dn_only_s && !at_bot_s) begin
          state_nxt_s = ST_FALLING;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RISING: begin
        if (both_s) begin
          state_nxt_s = ST_FAULT;
          code_nxt_s  = FLT_CONFLICT;
        end else if (bus.enc_tick && at_top_s && bus.UP_motor) begin
          state_nxt_s = ST_FAULT;
          code_nxt_s  = FLT_OVERRUN;
        end else if (expired_s) begin
          state_nxt_s = ST_FAULT;
          code_nxt_s  = FLT_STALL;
        end else begin
          // A tick is still counted in the cycle the command drops or reverses.
          if (bus.enc_tick && !at_top_s) begin
            pos_nxt_s = pos_r + POS_W'(1);
          end else begin
            pos_nxt_s = pos_r;
          end
          if (none_s) begin
            state_nxt_s = ST_IDLE;
          end else if (dn_only_s) begin
            state_nxt_s = ST_FALLING;
          end else begin
            state_nxt_s = ST_RISING;
          end
        end
      end
      ST_FALLING: begin
        if (both_s) begin
          state_nxt_s = ST_FAULT;
          code_nxt_s  = FLT_CONFLICT;
        end else if (bus.enc_tick && at_bot_s && bus.DN_motor) begin
          state_nxt_s = ST_FAULT;
          code_nxt_s  = FLT_OVERRUN;
        end else if (expired_s) begin
          state_nxt_s = ST_FAULT;
          code_nxt_s  = FLT_STALL;
        end else begin
          if (bus.enc_tick && !at_bot_s) begin
            pos_nxt_s = pos_r - POS_W'(1);
          end else begin
            pos_nxt_s = pos_r;
          end
          if (none_s) begin
            state_nxt_s = ST_IDLE;
          end else if (up_only_s) begin
            state_nxt_s = ST_RISING;
          end else begin
            state_nxt_s = ST_FALLING;
          end
        end
      end
      ST_FAULT: begin
        // Position frozen; leave only on acknowledge with both commands released.
        if (bus.fault_clr && none_s) begin
          state_nxt_s = ST_IDLE;
          code_nxt_s  = FLT_NONE;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s = ST_FAULT;
        code_nxt_s  = FLT_CONFLICT;
      end
    endcase
  end

  // FSM, position and fault registers, including the registered fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      pos_r   <= '0;
      code_r  <= FLT_NONE;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pos_r   <= pos_nxt_s;
      code_r  <= code_nxt_s;
      fault_r <= (state_nxt_s == ST_FAULT);
    end
  end

  assign bus.position   = pos_r;
  assign bus.UP_MAX     = at_top_s;
  assign bus.DN_MAX     = at_bot_s;
  assign bus.fault      = fault_r;
  assign bus.motor_en   = !fault_r;
  assign bus.fault_code = code_r;

endmodule

// File: doc/door_travel_monitor.md
Name: door_travel_monitor

Overview:
- Limit-sensing end of the garage-door motor interface.
- Consumes the UP_motor/DN_motor commands issued by the door controller, plus encoder ticks from the drive. Tracks door position and generates the UP_MAX/DN_MAX limit signals the controller consumes.
- Also detects command conflicts, stalls and limit overruns, and gates the motor drivers off on any fault.

Parameters:
- POS_W, 8, width of position counter
- POS_MAX, 200, encoder ticks for full travel (closed=0, open=POS_MAX); must be < 2**POS_W
- STALL_CYC, 1000, max cycles without enc_tick while driving before stall fault
- STALL_W, 10, width of stall counter; must satisfy 2**STALL_W > STALL_CYC

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- UP_motor  input  1  raise command from door controller
- DN_motor  input  1  lower command from door controller
- enc_tick  input  1  one-cycle pulse per travel increment
- fault_clr  input  1  fault acknowledge, level-sampled
- UP_MAX  output  1  door fully open (position==POS_MAX)
- DN_MAX  output  1  door fully closed (position==0)
- position  output  POS_W  current door position in ticks
- motor_en  output  1  motor driver enable; 0 in FAULT
- fault  output  1  1 while in FAULT
- fault_code  output  2  00 none, 01 conflict, 10 stall, 11 overrun

Behaviour:
- Reset (rst=0, async) sets:
  - state=IDLE, position=0, stall counter=0, fault_code=00
  - Resulting outputs: DN_MAX=1, UP_MAX=0, motor_en=1, fault=0
- Reset mid-travel has the same effect: position returns to 0.
- UP_MAX/DN_MAX are decoded combinationally from the registered position and change in the same cycle position updates.
- motor_en=0 and fault=1 iff state==FAULT.
- States: IDLE, RISING, FALLING, FAULT, 2-bit encoded.

IDLE transitions:
- UP_motor&DN_motor -> FAULT, code 01.
- UP_motor only, !UP_MAX -> RISING.
- DN_motor only, !DN_MAX -> FALLING.
- A command asserted while already at that limit -> stay IDLE.
- enc_tick is ignored; coasting is not modelled.

RISING (FALLING is symmetric: decrement, floor 0, DN_MAX/DN_motor):
- Priority within a cycle: conflict > overrun > stall > direction change.
- UP_motor&DN_motor -> FAULT, code 01; position unchanged that cycle.
- enc_tick with position<POS_MAX -> position+1, stall counter cleared.
- enc_tick with position==POS_MAX and UP_motor=1 -> FAULT, code 11; position held (saturates).
- No tick -> stall counter+1; counter reaching STALL_CYC-1 with no tick -> FAULT, code 10.
- UP_motor=0, DN_motor=0 -> IDLE next cycle. A tick in that same cycle is still counted.
- DN_motor only -> FALLING, stall counter cleared. Direct reversal is legal.

FAULT:
- Position is frozen; ticks are ignored.
- fault_code holds the first cause.
- Exit to IDLE only when fault_clr=1 and UP_motor=0 and DN_motor=0; fault_code clears to 00 and position is retained.
- fault_clr outside FAULT has no effect.

Latency and counters:
- Command to state change: 1 cycle.
- Tick to position/limit update: 1 cycle.
- The stall counter runs only in RISING/FALLING and is cleared on any state change.

Decomposition:
- door_pkg holds:
  - state encodings, with IDLE=2'b00 matching the controller's encoding
  - fault codes FLT_NONE, FLT_CONFLICT, FLT_STALL, FLT_OVERRUN
- One sub-module, door_stall_timer:
  - inputs: clk, rst, run, tick
  - output: expired
  - parameterised by STALL_CYC and STALL_W
- The position counter and FSM stay in the top module.

Test Plan:
- Bench parameters: POS_MAX=8, STALL_CYC=16.
- Reset then idle: rst low 3 cycles -> position=0, DN_MAX=1, UP_MAX=0, motor_en=1, fault=0, fault_code=00.
- Full open: UP_motor=1, 8 ticks spaced 4 cycles apart -> position 1..8; UP_MAX=1 one cycle after the 8th tick. Drop UP_motor -> IDLE, no fault.
- Conflict: in RISING at position=3, assert UP_motor=DN_motor=1 -> next cycle fault=1, fault_code=01, motor_en=0, position=3. fault_clr with motors low -> IDLE, fault_code=00, position=3.
- Stall: DN_motor=1 from position=5, no ticks -> fault=1, code 10, exactly 16 cycles after entering FALLING; position=5.
- Overrun: at position=8 in RISING, tick with UP_motor still 1 -> fault_code=11, position stays 8.
- Edge cases:
  - DN_motor=1 at position=0 -> state stays IDLE.
  - Tick coincident with UP_motor deassert at position=6 -> position=7.
  - Async reset mid-FALLING -> immediate position=0, DN_MAX=1.
